// File: rtl/robo_coletor_param_if.sv
// Sensor and actuator bundle between the front end, the collector controller and the drive/arm.
// The sensor/test side uses master and the controller uses slave.
interface robo_coletor_param_if #(
    parameter int ITEM_W = 8
);
    logic              head;
    logic              left;
    logic              under;
    logic              barrier;
    logic              resume;
    logic              forward;
    logic              turn;
    logic              remove;
    logic              standby;
    logic [1:0]        fault_code;
    logic [ITEM_W-1:0] items;

    modport master (
        output head, left, under, barrier, resume,
        input  forward, turn, remove, standby, fault_code, items
    );

    modport slave (
        input  head, left, under, barrier, resume,
        output forward, turn, remove, standby, fault_code, items
    );
endinterface

// File: rtl/robo_coletor_param.sv
// Timed left-wall-following collector controller with registered Moore outputs,
// trapped/no-floor/removal-timeout faults and a saturating item counter.
module robo_coletor_param #(
    parameter int STEP_CYCLES   = 8,
    parameter int TURN_CYCLES   = 16,
    parameter int LOST_TURNS    = 3,
    parameter int REMOVE_CYCLES = 32,
    parameter int MAX_TURNS     = 4,
    parameter int TIMER_W       = 16,
    parameter int ITEM_W        = 8
) (
    input logic                 clock,
    input logic                 reset,
    robo_coletor_param_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_TURNS + 1);

    localparam logic [TIMER_W-1:0] STEP_LAST   = TIMER_W'(STEP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TURN_LAST   = TIMER_W'(TURN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOST_LAST   = TIMER_W'(LOST_TURNS * TURN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] REMOVE_LAST = TIMER_W'(REMOVE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TRAP_AT     = CNT_W'(MAX_TURNS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SENSE   = 3'd1,
        TURN    = 3'd2,
        ADVANCE = 3'd3,
        REMOVE  = 3'd4,
        STANDBY = 3'd5
    } state_t;

    state_t             state, state_nx;
    logic [TIMER_W-1:0] timer, timer_nx;
    logic [CNT_W-1:0]   turn_cnt, turn_cnt_nx;
    logic               lost, lost_nx;
    logic               trapped, trapped_nx;
    logic [1:0]         fault, fault_nx;
    logic [ITEM_W-1:0]  items_q, items_nx;
    logic               s_head, s_left, s_under, s_barrier;
    logic               forward_q, turn_q, remove_q, standby_q;
    logic [CNT_W-1:0]   turn_cnt_inc;

    assign turn_cnt_inc = turn_cnt + 1'b1;

    always_comb begin
        state_nx    = state;
        timer_nx    = timer;
        turn_cnt_nx = turn_cnt;
        lost_nx     = lost;
        trapped_nx  = trapped;
        fault_nx    = fault;
        items_nx    = items_q;
        case (state)
            IDLE: state_nx = SENSE;
            SENSE: begin
                timer_nx   = '0;
                trapped_nx = 1'b0;
                if (!s_under) begin
                    state_nx = STANDBY;
                    fault_nx = 2'd1;
                end else if (s_barrier) begin
                    state_nx = REMOVE;
                end else if (!s_left || s_head) begin
                    // Trapped entry occupies TURN for one cycle with the motor idle.
                    state_nx    = TURN;
                    lost_nx     = !s_left;
                    turn_cnt_nx = turn_cnt_inc;
                    trapped_nx  = (turn_cnt_inc == TRAP_AT);
                end else begin
                    state_nx    = ADVANCE;
                    turn_cnt_nx = '0;
                end
            end
            TURN: begin
                if (trapped) begin
                    state_nx = STANDBY;
                    fault_nx = 2'd2;
                end else if (timer == (lost ? LOST_LAST : TURN_LAST)) begin
                    timer_nx = '0;
                    if (lost) begin
                        state_nx    = ADVANCE;
                        turn_cnt_nx = '0;
                    end else begin
                        state_nx = SENSE;
                    end
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            ADVANCE: begin
                if (!s_under) begin
                    state_nx = STANDBY;
                    fault_nx = 2'd1;
                end else if (timer == STEP_LAST) begin
                    state_nx = SENSE;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            REMOVE: begin
                // A barrier that clears on the deadline cycle still counts as a success.
                if (!s_barrier) begin
                    state_nx = SENSE;
                    if (items_q != {ITEM_W{1'b1}}) items_nx = items_q + 1'b1;
                end else if (timer == REMOVE_LAST) begin
                    state_nx = STANDBY;
                    fault_nx = 2'd3;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            STANDBY: begin
                if (bus.resume && bus.under) begin
                    state_nx    = IDLE;
                    fault_nx    = 2'd0;
                    turn_cnt_nx = '0;
                    trapped_nx  = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            timer     <= '0;
            turn_cnt  <= '0;
            lost      <= 1'b0;
            trapped   <= 1'b0;
            fault     <= 2'd0;
            items_q   <= '0;
            s_head    <= 1'b0;
            s_left    <= 1'b0;
            s_under   <= 1'b0;
            s_barrier <= 1'b0;
            forward_q <= 1'b0;
            turn_q    <= 1'b0;
            remove_q  <= 1'b0;
            standby_q <= 1'b0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            turn_cnt  <= turn_cnt_nx;
            lost      <= lost_nx;
            trapped   <= trapped_nx;
            fault     <= fault_nx;
            items_q   <= items_nx;
            s_head    <= bus.head;
            s_left    <= bus.left;
            s_under   <= bus.under;
            s_barrier <= bus.barrier;
            // Outputs follow the state being entered so they assert on its first cycle.
            forward_q <= (state_nx == ADVANCE);
            turn_q    <= (state_nx == TURN) && !trapped_nx;
            remove_q  <= (state_nx == REMOVE);
            standby_q <= (state_nx == STANDBY);
        end
    end

    assign bus.forward    = forward_q;
    assign bus.turn       = turn_q;
    assign bus.remove     = remove_q;
    assign bus.standby    = standby_q;
    assign bus.fault_code = fault;
    assign bus.items      = items_q;
endmodule

// File: tb/tb_robo_coletor_param.sv
// Bench for robo_coletor_param: directed vector table, corner-case sequences and
// randomized stimulus against an activity/countdown reference model.
module tb_robo_coletor_param;
    localparam int STEP   = 3;
    localparam int TURNC  = 4;
    localparam int LOST   = 3;
    localparam int REMC   = 8;
    localparam int MAXT   = 4;

    localparam int A_IDLE = 0, A_SENSE = 1, A_TURN = 2, A_TRAP = 3, A_STEP = 4, A_REMOVE = 5, A_PARK = 6;
    localparam int S_FWD = 0, S_TURN = 1, S_REM = 2, S_STBY = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    robo_coletor_param_if #(.ITEM_W(8)) bus();

    robo_coletor_param #(
        .STEP_CYCLES(STEP), .TURN_CYCLES(TURNC), .LOST_TURNS(LOST),
        .REMOVE_CYCLES(REMC), .MAX_TURNS(MAXT), .TIMER_W(16), .ITEM_W(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    // Reference model: current activity plus cycles left in it.
    int   act = A_IDLE, remaining = 0, streak = 0, m_fault = 0, m_items = 0;
    logic turn_then_step = 1'b0;
    logic sh = 1'b0, sl = 1'b0, su = 1'b0, sb = 1'b0;

    task automatic model_step();
        if (!reset) begin
            act = A_IDLE; remaining = 0; streak = 0; m_fault = 0; m_items = 0;
            turn_then_step = 1'b0;
            sh = 1'b0; sl = 1'b0; su = 1'b0; sb = 1'b0;
        end else begin
            case (act)
                A_IDLE: act = A_SENSE;
                A_SENSE: begin
                    if (!su) begin act = A_PARK; m_fault = 1; end
                    else if (sb) begin act = A_REMOVE; remaining = REMC; end
                    else if (!sl || sh) begin
                        streak++;
                        if (streak == MAXT) act = A_TRAP;
                        else begin
                            act = A_TURN;
                            remaining = (!sl ? LOST : 1) * TURNC;
                            turn_then_step = !sl;
                        end
                    end else begin act = A_STEP; remaining = STEP; streak = 0; end
                end
                A_TURN: begin
                    remaining--;
                    if (remaining == 0) begin
                        if (turn_then_step) begin act = A_STEP; remaining = STEP; streak = 0; end
                        else act = A_SENSE;
                    end
                end
                A_TRAP: begin act = A_PARK; m_fault = 2; end
                A_STEP: begin
                    if (!su) begin act = A_PARK; m_fault = 1; end
                    else begin
                        remaining--;
                        if (remaining == 0) act = A_SENSE;
                    end
                end
                A_REMOVE: begin
                    if (!sb) begin
                        if (m_items < 255) m_items++;
                        act = A_SENSE;
                    end else begin
                        remaining--;
                        if (remaining == 0) begin act = A_PARK; m_fault = 3; end
                    end
                end
                A_PARK: if (bus.resume && bus.under) begin act = A_IDLE; m_fault = 0; streak = 0; end
                default: act = A_IDLE;
            endcase
            sh = bus.head; sl = bus.left; su = bus.under; sb = bus.barrier;
        end
    endtask

    function automatic logic [5:0] model_ctl();
        return {act == A_STEP, act == A_TURN, act == A_REMOVE, act == A_PARK, 2'(m_fault)};
    endfunction

    function automatic logic [5:0] dut_ctl();
        return {bus.forward, bus.turn, bus.remove, bus.standby, bus.fault_code};
    endfunction

    function automatic logic sig(input int which);
        case (which)
            S_FWD:   return bus.forward;
            S_TURN:  return bus.turn;
            S_REM:   return bus.remove;
            default: return bus.standby;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        check("model_ctl", 32'(dut_ctl()), 32'(model_ctl()));
        check("model_items", 32'(bus.items), 32'(m_items));
    endtask

    task automatic wait_sig(input int which, input string name);
        int k = 0;
        while (sig(which) !== 1'b1 && k < 60) begin tick(); k++; end
        check(name, 32'(sig(which)), 32'd1);
    endtask

    task automatic count_high(input int which, output int n);
        n = 0;
        while (sig(which) === 1'b1 && n < 200) begin n++; tick(); end
    endtask

    typedef struct {
        logic       rst_n, head, left, under, barrier, resume;
        logic [5:0] ctl;
        logic [7:0] items;
    } vec_t;

    vec_t tbl[20];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int saved;
        // Reset, cruise along the wall, then one wall-ahead quarter turn.
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 8'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 8'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 8'd0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b100000, 8'd0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b100000, 8'd0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b100000, 8'd0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 8'd0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b100000, 8'd0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b100000, 8'd0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b100000, 8'd0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 8'd0};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b010000, 8'd0};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b010000, 8'd0};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b010000, 8'd0};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b010000, 8'd0};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 8'd0};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b100000, 8'd0};
        tbl[17] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b100000, 8'd0};
        tbl[18] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b100000, 8'd0};
        tbl[19] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 8'd0};

        bus.head = 1'b0; bus.left = 1'b1; bus.under = 1'b1; bus.barrier = 1'b0; bus.resume = 1'b0;

        for (int i = 0; i < 20; i++) begin
            reset = tbl[i].rst_n;
            bus.head = tbl[i].head; bus.left = tbl[i].left; bus.under = tbl[i].under;
            bus.barrier = tbl[i].barrier; bus.resume = tbl[i].resume;
            tick();
            check($sformatf("tbl_ctl[%0d]", i), 32'(dut_ctl()), 32'(tbl[i].ctl));
            check($sformatf("tbl_items[%0d]", i), 32'(bus.items), 32'(tbl[i].items));
        end

        // Lost wall: three quarter turns, then a forced step with no SENSE gap.
        bus.left = 1'b0;
        wait_sig(S_TURN, "lost_turn_start");
        count_high(S_TURN, n);
        check("lost_turn_len", 32'(n), 32'(LOST * TURNC));
        check("lost_forced_step", 32'(bus.forward), 32'd1);
        bus.left = 1'b1;
        count_high(S_FWD, n);
        check("lost_step_len", 32'(n), 32'(STEP));

        // Short barrier: held five remove cycles, seen one cycle late by the sensor stage.
        bus.barrier = 1'b1;
        wait_sig(S_REM, "remove_start");
        saved = bus.items;
        repeat (4) tick();
        bus.barrier = 1'b0;
        count_high(S_REM, n);
        check("remove_tail_len", 32'(n), 32'd2);
        check("remove_item_inc", 32'(bus.items), 32'(saved + 1));

        // Barrier that never clears: removal timeout, then resume.
        bus.barrier = 1'b1;
        wait_sig(S_REM, "timeout_remove_start");
        saved = bus.items;
        count_high(S_REM, n);
        check("timeout_remove_len", 32'(n), 32'(REMC));
        check("timeout_standby", 32'(bus.standby), 32'd1);
        check("timeout_fault", 32'(bus.fault_code), 32'd3);
        bus.barrier = 1'b0; bus.head = 1'b1; bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;
        check("resume_fault_clear", 32'(bus.fault_code), 32'd0);
        check("resume_standby_clear", 32'(bus.standby), 32'd0);
        check("resume_items_kept", 32'(bus.items), 32'(saved));

        // Boxed in: three full turns, fourth entry parks with the trapped fault.
        for (int t = 0; t < MAXT - 1; t++) begin
            wait_sig(S_TURN, "boxed_turn_start");
            count_high(S_TURN, n);
            check($sformatf("boxed_turn_len[%0d]", t), 32'(n), 32'(TURNC));
        end
        wait_sig(S_STBY, "trapped_standby");
        check("trapped_fault", 32'(bus.fault_code), 32'd2);

        // Floor lost mid-step; resume without floor is ignored.
        bus.head = 1'b0; bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;
        wait_sig(S_FWD, "floor_step_start");
        tick();
        bus.under = 1'b0;
        wait_sig(S_STBY, "floor_standby");
        check("floor_fault", 32'(bus.fault_code), 32'd1);
        bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;
        tick();
        check("ignored_resume_standby", 32'(bus.standby), 32'd1);
        check("ignored_resume_fault", 32'(bus.fault_code), 32'd1);
        bus.under = 1'b1; bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;

        // Randomized traffic with sticky barriers and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 99) < 20) bus.head = ~bus.head;
            bus.left = ($urandom_range(0, 99) < 75);
            bus.under = ($urandom_range(0, 99) >= 3);
            if ($urandom_range(0, 99) < 8) bus.barrier = ~bus.barrier;
            bus.resume = ($urandom_range(0, 99) < 10);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/robo_coletor_param.md
Name: robo_coletor_param

Overview:
Parametrised successor to the collector-robot controller. It is a timed, registered-output left-wall-following FSM. Turns, steps and removals last a configurable number of clock cycles instead of a single cycle. The block detects trapped and stalled-removal faults, counts collected items, and supports restart from standby. It sits between the sensor front end and the drive/arm actuators.

Parameters:
STEP_CYCLES, 8, cycles forward is held per advance step (>=1)
TURN_CYCLES, 16, cycles turn is held per quarter turn (>=1)
LOST_TURNS, 3, quarter turns executed when the left wall is lost (1..3)
REMOVE_CYCLES, 32, max cycles remove may stay asserted before a fault (>=1)
MAX_TURNS, 4, consecutive TURN entries without an ADVANCE that trigger the trapped fault (>=2)
TIMER_W, 16, width of the action timer; must hold LOST_TURNS*TURN_CYCLES and REMOVE_CYCLES
ITEM_W, 8, width of the collected-item counter

Ports:
clock  in  1  system clock; all state changes on the rising edge
reset  in  1  synchronous, active-low reset
head  in  1  fixed wall directly ahead
left  in  1  wall present on the left side
under  in  1  floor detected under the robot (0 = lifted or cliff)
barrier  in  1  removable object ahead
resume  in  1  single-cycle request to leave STANDBY
forward  out  1  drive forward
turn  out  1  rotate right in place
remove  out  1  actuate removal arm
standby  out  1  high while in STANDBY
fault_code  out  2  0 none, 1 no floor, 2 trapped, 3 removal timeout
items  out  ITEM_W  count of successful removals, saturating

Behaviour:
- One clock, `clock`. Reset is synchronous and active-low on `reset`.
- While reset=0 at a rising edge: state=IDLE; all outputs 0 (forward, turn, remove, standby 0; fault_code 0; items 0); timer, turn counter and sensor registers cleared. Reset mid-action aborts the action immediately.
- Sensors are registered every cycle (s_head, s_left, s_under, s_barrier). All decisions use the registered copies, so input-to-decision latency is 1 cycle.
- Outputs are registered and Moore-style. forward=1 only in ADVANCE, turn=1 only in TURN, remove=1 only in REMOVE, standby=1 only in STANDBY. Outputs assert in the first cycle the state is occupied.
- IDLE: occupied 1 cycle, then SENSE.
- SENSE: occupied 1 cycle. Decision priority, first match wins:
  - s_under=0 -> STANDBY, fault 1.
  - s_barrier=1 -> REMOVE; timer=0.
  - s_left=0 -> TURN with quarters=LOST_TURNS and lost=1.
  - s_head=1 -> TURN with quarters=1 and lost=0.
  - otherwise -> ADVANCE.
- TURN: on entry the consecutive-turn counter increments. If the post-increment value equals MAX_TURNS, the next state is STANDBY with fault 2, and turn stays 0 for that entry. Otherwise turn=1 for exactly quarters*TURN_CYCLES cycles. Afterwards: lost=1 -> ADVANCE (forced step to regain the wall); lost=0 -> SENSE.
- ADVANCE: on entry the consecutive-turn counter clears. forward=1 for exactly STEP_CYCLES cycles, then SENSE. If s_under=0 during ADVANCE: next edge -> STANDBY, fault 1.
- REMOVE: remove=1 while s_barrier=1.
  - s_barrier falls -> SENSE next edge; items += 1, saturating at all-ones.
  - timer reaches REMOVE_CYCLES with s_barrier still 1 -> STANDBY, fault 3; items unchanged.
  - If both happen on the same cycle, the successful removal wins.
- STANDBY: all actuators 0 and fault_code held. resume=1 together with under=1 (raw input) -> IDLE; fault_code clears to 0 and the turn counter clears. resume with under=0 is ignored.
- items is retained across STANDBY and clears only on reset.
- No state is unreachable. Any illegal encoding recovers to IDLE on the next edge.

Test Plan:
(Parameters for all scenarios: STEP_CYCLES=3, TURN_CYCLES=4, LOST_TURNS=3, REMOVE_CYCLES=8, MAX_TURNS=4.)
1. Reset low 2 cycles, then release with under=1, left=1, head=0, barrier=0 -> IDLE, SENSE, then forward=1 for exactly 3 cycles; SENSE repeats; turn and remove stay 0.
2. head=1, left=1, under=1 -> turn=1 for exactly 4 cycles, then SENSE.
3. left=0, under=1 -> turn=1 for 12 cycles, then forward=1 for 3 cycles with no SENSE in between.
4. barrier=1 for 5 cycles, then 0 -> remove=1 for about 5 cycles; items goes 0->1; returns to SENSE.
5. barrier held at 1 -> remove=1 for 8 cycles, then standby=1 and fault_code=3; resume with under=1 -> IDLE and fault_code=0; items preserved.
6. Boxed in (head=1, left=1 held) -> 3 turns of 4 cycles each, then on the 4th entry standby=1 and fault_code=2. Separately: under dropped to 0 mid-ADVANCE -> STANDBY with fault_code=1, and resume with under=0 is ignored.
